// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive framer: FSM states, framing constants,
// status bit positions and the byte-wide CRC-32 update step.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DA       = 3'd2,
    ST_SA       = 3'd3,
    ST_TYPE     = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_STATUS   = 3'd6,
    ST_DROP     = 3'd7
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  localparam int ERR_CRC   = 0;
  localparam int ERR_PHY   = 1;
  localparam int ERR_RUNT  = 2;
  localparam int ERR_GIANT = 3;
  localparam int ERR_W     = 4;

  localparam int RX_DLY    = 6;
  localparam int FCS_BYTES = 4;
  // Index (from the first DA byte) of the last byte of each header field.
  localparam int DA_LAST   = 5;
  localparam int SA_LAST   = 11;
  localparam int TYPE_LAST = 13;

  // Non-reflected register, data bits shifted in LSB first as they leave the wire.
  function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_dly.sv
// Fixed-depth byte+valid shift line; clr discards everything in flight.
module eth_rx_dly #(
  parameter int DW    = 9,
  parameter int DEPTH = 6
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] out_data,
  output logic          out_vld
);

  logic [DEPTH-1:0][DW-1:0] data_reg;
  logic [DEPTH-1:0]         vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [DW-1:0] data_src;
      logic          vld_src;
      if (gi == 0) begin : g_head
        assign data_src = in_data;
        assign vld_src  = in_vld;
      end else begin : g_link
        assign data_src = data_reg[gi-1];
        assign vld_src  = vld_reg[gi-1];
      end
      always_ff @(posedge iclk) begin
        if (irst || clr) begin
          data_reg[gi] <= '0;
          vld_reg[gi]  <= 1'b0;
        end else begin
          data_reg[gi] <= data_src;
          vld_reg[gi]  <= vld_src;
        end
      end
    end
  endgenerate

  assign out_data = data_reg[DEPTH-1];
  assign out_vld  = vld_reg[DEPTH-1];

endmodule

// File: rtl/eth_frame_rx.sv
// GMII receive framer: strips preamble/SFD/FCS, emits DA..payload with sof/eof and a status pulse.
// Optional destination-address filter: define ETH_FRAME_RX_DA_FILTER_EN.
module eth_frame_rx
  import eth_rx_pkg::*;
#(
  parameter int          MAX_PREAMBLE = 7,
  parameter int          MIN_FRAME    = 64,
  parameter int          MAX_FRAME    = 1518,
  parameter int          LEN_W        = 11,
  parameter logic [47:0] STATION_MAC  = 48'h0,
  parameter bit          ACCEPT_MCAST = 1'b1
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [7:0]       irx_data,
  input  logic             irx_dv,
  input  logic             irx_er,
  output logic [7:0]       o_data,
  output logic             o_dv,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_status_vld,
  output logic             o_frame_ok,
  output logic [ERR_W-1:0] o_err,
  output logic [LEN_W-1:0] o_len,
  output logic [2:0]       o_state,
  output logic [15:0]      o_drop_cnt
);

  rx_state_e        state_reg, state_next;
  logic [7:0]       pre_cnt_reg, pre_cnt_next;
  logic [LEN_W-1:0] n_reg, n_next;
  logic [31:0]      crc_reg, crc_next;
  logic             er_reg, er_next;
  logic             drain_reg, drain_next;
  logic             drain_cnt_reg, drain_cnt_next;

  logic             frame_byte;
  logic             dly_clr;
  logic             filt_drop;
  logic             da_accept;
  logic             sof_in;
  logic [8:0]       dly_data;
  logic             dly_vld;
  logic             emit;

  logic [7:0]       data_out_reg;
  logic             dv_out_reg, sof_out_reg, eof_out_reg;
  logic             status_vld_reg, frame_ok_reg;
  logic [ERR_W-1:0] err_reg, err_val;
  logic [LEN_W-1:0] len_reg, len_val;

  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    n_next         = n_reg;
    crc_next       = crc_reg;
    er_next        = er_reg;
    drain_next     = drain_reg;
    drain_cnt_next = drain_cnt_reg;
    frame_byte     = 1'b0;
    dly_clr        = 1'b0;
    filt_drop      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (irx_dv) begin
          if (irx_data == PREAMBLE_BYTE) begin
            state_next   = ST_PREAMBLE;
            pre_cnt_next = 8'd1;
          end else begin
            state_next = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!irx_dv) begin
          state_next = ST_IDLE;
        end else if (irx_er) begin
          state_next = ST_DROP;
        end else if (irx_data == SFD_BYTE) begin
          state_next     = ST_DA;
          crc_next       = CRC_INIT;
          n_next         = '0;
          er_next        = 1'b0;
          drain_next     = 1'b0;
          drain_cnt_next = 1'b0;
        end else if (irx_data == PREAMBLE_BYTE) begin
          if (pre_cnt_reg >= 8'(MAX_PREAMBLE)) state_next = ST_DROP;
          else                                  pre_cnt_next = pre_cnt_reg + 8'd1;
        end else begin
          state_next = ST_DROP;
        end
      end
      ST_DA, ST_SA, ST_TYPE, ST_PAYLOAD: begin
        // Hold the field state while the tail of the frame drains out of the delay line.
        if (drain_reg) begin
          if (drain_cnt_reg) begin
            state_next = ST_STATUS;
            drain_next = 1'b0;
            dly_clr    = 1'b1;
          end else begin
            drain_cnt_next = 1'b1;
          end
        end else if (!irx_dv) begin
          drain_next     = 1'b1;
          drain_cnt_next = 1'b0;
        end else begin
          frame_byte = 1'b1;
          crc_next   = eth_crc32_8d(crc_reg, irx_data);
          n_next     = (n_reg == {LEN_W{1'b1}}) ? n_reg : n_reg + LEN_W'(1);
          er_next    = er_reg | irx_er;
          if (state_reg == ST_DA && n_reg == LEN_W'(DA_LAST)) begin
            if (da_accept) begin
              state_next = ST_SA;
            end else begin
              state_next = ST_DROP;
              dly_clr    = 1'b1;
              filt_drop  = 1'b1;
            end
          end else if (state_reg == ST_SA && n_reg == LEN_W'(SA_LAST)) begin
            state_next = ST_TYPE;
          end else if (state_reg == ST_TYPE && n_reg == LEN_W'(TYPE_LAST)) begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_STATUS: state_next = ST_IDLE;
      ST_DROP: begin
        if (!irx_dv) state_next = ST_IDLE;
      end
      default: state_next = ST_DROP;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg     <= ST_DROP;
      pre_cnt_reg   <= '0;
      n_reg         <= '0;
      crc_reg       <= CRC_INIT;
      er_reg        <= 1'b0;
      drain_reg     <= 1'b0;
      drain_cnt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= pre_cnt_next;
      n_reg         <= n_next;
      crc_reg       <= crc_next;
      er_reg        <= er_next;
      drain_reg     <= drain_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  assign sof_in = (state_reg == ST_DA) && (n_reg == '0);

  eth_rx_dly #(
    .DW    (9),
    .DEPTH (RX_DLY)
  ) u_dly (
    .iclk     (iclk),
    .irst     (irst),
    .clr      (dly_clr),
    .in_data  ({sof_in, irx_data}),
    .in_vld   (frame_byte),
    .out_data (dly_data),
    .out_vld  (dly_vld)
  );

  // Byte leaving on the first drain cycle is the last non-FCS byte; later ones are FCS.
  assign emit = dly_vld && !(drain_reg && drain_cnt_reg);

  always_comb begin
    err_val            = '0;
    err_val[ERR_CRC]   = (crc_reg != CRC_RESIDUE);
    err_val[ERR_PHY]   = er_reg;
    err_val[ERR_RUNT]  = (n_reg < LEN_W'(MIN_FRAME));
    err_val[ERR_GIANT] = (n_reg > LEN_W'(MAX_FRAME));
    len_val            = (n_reg > LEN_W'(FCS_BYTES)) ? n_reg - LEN_W'(FCS_BYTES) : '0;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      data_out_reg   <= '0;
      dv_out_reg     <= 1'b0;
      sof_out_reg    <= 1'b0;
      eof_out_reg    <= 1'b0;
      status_vld_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
      err_reg        <= '0;
      len_reg        <= '0;
    end else begin
      data_out_reg   <= emit ? dly_data[7:0] : 8'h00;
      dv_out_reg     <= emit;
      sof_out_reg    <= emit && dly_data[8];
      eof_out_reg    <= emit && drain_reg && !drain_cnt_reg;
      status_vld_reg <= (state_next == ST_STATUS);
      if (state_next == ST_STATUS) begin
        frame_ok_reg <= (err_val == '0);
        err_reg      <= err_val;
        len_reg      <= len_val;
      end
    end
  end

`ifdef ETH_FRAME_RX_DA_FILTER_EN
  logic [39:0] da_sh_reg;
  logic [47:0] da_full;
  logic [15:0] drop_cnt_reg;

  assign da_full   = {da_sh_reg, irx_data};
  assign da_accept = (da_full == STATION_MAC) || (&da_full) || (ACCEPT_MCAST && da_full[40]);

  always_ff @(posedge iclk) begin
    if (irst) begin
      da_sh_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (frame_byte && state_reg == ST_DA) da_sh_reg <= {da_sh_reg[31:0], irx_data};
      if (filt_drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_reg;
`else
  logic unused_cfg;
  assign da_accept  = 1'b1;
  assign unused_cfg = ^{STATION_MAC, ACCEPT_MCAST, filt_drop};
  assign o_drop_cnt = '0;
`endif

  assign o_data       = data_out_reg;
  assign o_dv         = dv_out_reg;
  assign o_sof        = sof_out_reg;
  assign o_eof        = eof_out_reg;
  assign o_status_vld = status_vld_reg;
  assign o_frame_ok   = frame_ok_reg;
  assign o_err        = err_reg;
  assign o_len        = len_reg;
  assign o_state      = state_reg;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed bench for eth_frame_rx: builds frames with a reflected CRC-32 model and checks stream, timing and status.
module tb_eth_frame_rx;

  localparam logic [47:0] STATION = 48'h0200_0000_0001;
`ifdef ETH_FRAME_RX_DA_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [7:0]  irx_data = 8'h00;
  logic        irx_dv = 1'b0;
  logic        irx_er = 1'b0;
  logic [7:0]  o_data;
  logic        o_dv, o_sof, o_eof, o_status_vld, o_frame_ok;
  logic [3:0]  o_err;
  logic [10:0] o_len;
  logic [2:0]  o_state;
  logic [15:0] o_drop_cnt;

  eth_frame_rx #(.STATION_MAC(STATION)) dut (
    .iclk         (iclk),
    .irst         (irst),
    .irx_data     (irx_data),
    .irx_dv       (irx_dv),
    .irx_er       (irx_er),
    .o_data       (o_data),
    .o_dv         (o_dv),
    .o_sof        (o_sof),
    .o_eof        (o_eof),
    .o_status_vld (o_status_vld),
    .o_frame_ok   (o_frame_ok),
    .o_err        (o_err),
    .o_len        (o_len),
    .o_state      (o_state),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  got_q[$];
  int          sof_cyc, eof_cyc, stat_cyc, stat_cnt;
  logic        stat_ok;
  logic [3:0]  stat_err;
  logic [10:0] stat_len;
  int          t_first, f_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge iclk) begin
    if (o_dv) begin
      got_q.push_back(o_data);
      if (o_sof) sof_cyc = cyc;
      if (o_eof) eof_cyc = cyc;
    end
    if (o_status_vld) begin
      stat_cnt++;
      stat_cyc = cyc;
      stat_ok  = o_frame_ok;
      stat_err = o_err;
      stat_len = o_len;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    sof_cyc  = -1;
    eof_cyc  = -1;
    stat_cyc = -1;
    stat_cnt = 0;
    stat_ok  = 1'b0;
    stat_err = '0;
    stat_len = '0;
  endtask

  // Reflected (wire-order) CRC-32 as transmitted by a MAC.
  function automatic logic [31:0] crc_refl(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input logic [47:0] da, input int ndata, input bit add_fcs);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    frame_q.delete();
    for (int i = 0; i < ndata; i++) begin
      if (i < 6)       b = da[47-8*i -: 8];
      else if (i < 12) b = 8'hA0 + 8'(i);
      else if (i == 12) b = 8'h08;
      else if (i == 13) b = 8'h00;
      else             b = 8'(i * 37 + 11);
      frame_q.push_back(b);
    end
    if (add_fcs) begin
      c = 32'hFFFF_FFFF;
      foreach (frame_q[i]) c = crc_refl(c, frame_q[i]);
      fcs = ~c;
      frame_q.push_back(fcs[7:0]);
      frame_q.push_back(fcs[15:8]);
      frame_q.push_back(fcs[23:16]);
      frame_q.push_back(fcs[31:24]);
    end
  endtask

  task automatic send_frame(input int npre, input int er_idx, input int rst_idx);
    for (int i = 0; i < npre; i++) begin
      @(negedge iclk);
      irx_dv = 1'b1; irx_data = 8'h55; irx_er = 1'b0;
    end
    @(negedge iclk);
    irx_data = 8'hD5;
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge iclk);
      if (i == 0) t_first = cyc + 1;
      if (rst_idx >= 0 && i == rst_idx + 1) begin
        clear_mon();
        check_eq("rst_state", 32'(o_state), 32'd7);
      end
      irx_data = frame_q[i];
      irx_er   = (i == er_idx);
      irst     = (i == rst_idx);
    end
    @(negedge iclk);
    irx_dv = 1'b0; irx_data = 8'h00; irx_er = 1'b0; irst = 1'b0;
    f_cyc = cyc + 1;
    while (cyc < f_cyc + 3) @(negedge iclk);
    check_eq("idle_at_f3", 32'(o_state), 32'd0);
    repeat (10) @(negedge iclk);
  endtask

  task automatic check_frame(input string name, input int exp_bytes, input int exp_stat,
                             input logic [3:0] exp_err, input int exp_len);
    int bad;
    bad = 0;
    check_eq({name, ".nbytes"}, 32'(got_q.size()), 32'(exp_bytes));
    for (int i = 0; i < got_q.size() && i < frame_q.size(); i++)
      if (got_q[i] !== frame_q[i]) bad++;
    check_eq({name, ".data"}, 32'(bad), 32'd0);
    if (exp_bytes > 0) begin
      check_eq({name, ".sof_cyc"}, 32'(sof_cyc), 32'(t_first + 6));
      check_eq({name, ".eof_cyc"}, 32'(eof_cyc), 32'(f_cyc + 1));
      check_eq({name, ".span"}, 32'(eof_cyc - sof_cyc + 1), 32'(exp_bytes));
    end
    check_eq({name, ".nstat"}, 32'(stat_cnt), 32'(exp_stat));
    if (exp_stat > 0) begin
      check_eq({name, ".stat_cyc"}, 32'(stat_cyc), 32'(f_cyc + 2));
      check_eq({name, ".ok"}, 32'(stat_ok), 32'(exp_err == 4'b0000));
      check_eq({name, ".err"}, 32'(stat_err), 32'(exp_err));
      check_eq({name, ".len"}, 32'(stat_len), 32'(exp_len));
    end
    $display("frame %-8s bytes=%0d status=%0d ok=%0d err=%b len=%0d",
             name, got_q.size(), stat_cnt, stat_ok, stat_err, stat_len);
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge iclk);
    check_eq("rst.o_data", 32'(o_data), 32'd0);
    check_eq("rst.o_dv", 32'(o_dv), 32'd0);
    check_eq("rst.o_sof", 32'(o_sof), 32'd0);
    check_eq("rst.o_eof", 32'(o_eof), 32'd0);
    check_eq("rst.o_status_vld", 32'(o_status_vld), 32'd0);
    check_eq("rst.o_frame_ok", 32'(o_frame_ok), 32'd0);
    check_eq("rst.o_err", 32'(o_err), 32'd0);
    check_eq("rst.o_len", 32'(o_len), 32'd0);
    check_eq("rst.o_state", 32'(o_state), 32'd7);
    check_eq("rst.o_drop_cnt", 32'(o_drop_cnt), 32'd0);
    irst = 1'b0;
    repeat (3) @(negedge iclk);
    check_eq("post_rst_idle", 32'(o_state), 32'd0);
    $display("reset done state=%0d", o_state);

    clear_mon(); build(STATION, 60, 1'b1); send_frame(7, -1, -1);
    check_frame("good", 60, 1, 4'b0000, 60);

    clear_mon(); build(STATION, 60, 1'b1); frame_q[20] = frame_q[20] ^ 8'h01; send_frame(7, -1, -1);
    check_frame("badcrc", 60, 1, 4'b0001, 60);

    clear_mon(); build(STATION, 36, 1'b1); send_frame(7, -1, -1);
    check_frame("runt40", 36, 1, 4'b0100, 36);

    clear_mon(); build(STATION, 1596, 1'b1); send_frame(7, -1, -1);
    check_frame("giant", 1596, 1, 4'b1000, 1596);

    clear_mon(); build(STATION, 60, 1'b1); send_frame(7, 24, -1);
    check_frame("phy_er", 60, 1, 4'b0010, 60);

    clear_mon(); build(STATION, 60, 1'b1); send_frame(9, -1, -1);
    check_frame("pre9", 0, 0, 4'b0000, 0);

    clear_mon(); build(STATION, 1, 1'b1); send_frame(7, -1, -1);
    check_frame("n5", 1, 1, 4'b0100, 1);

    clear_mon(); build(STATION, 3, 1'b0); send_frame(7, -1, -1);
    check_frame("n3", 0, 1, 4'b0101, 0);

    clear_mon(); build(STATION, 60, 1'b1); send_frame(7, -1, 30);
    check_frame("rst_mid", 0, 0, 4'b0000, 0);

    clear_mon(); build(STATION, 60, 1'b1); send_frame(7, -1, -1);
    check_frame("after", 60, 1, 4'b0000, 60);

    clear_mon(); build(48'hFFFF_FFFF_FFFF, 60, 1'b1); send_frame(7, -1, -1);
    check_frame("bcast", 60, 1, 4'b0000, 60);

    clear_mon(); build(48'h0200_0000_0002, 60, 1'b1); send_frame(7, -1, -1);
    check_frame("da_miss", FILT ? 0 : 60, FILT ? 0 : 1, 4'b0000, 60);
    check_eq("drop_cnt", 32'(o_drop_cnt), FILT ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
